// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder stepped LSB-first over WIDTH cycles, accept-to-out_valid latency WIDTH;
// in_ready only in IDLE, result held in DONE until out_ready. Optional subtract port under SERIAL_ADD_SUB_EN.

module fulladd (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             cin_msb_q, cin_msb_d;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             fa_s, fa_co;

   // Subtraction is a + ~b + 1, so only the loaded B and initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : ci;
`else
   assign b_load = b;
   assign c_load = ci;
`endif

   fulladd u_fa (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      co_d      = co_q;
      cin_msb_d = cin_msb_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d   = S_RUN;
               a_sr_d    = a;
               b_sr_d    = b_load;
               carry_d   = c_load;
               cnt_d     = '0;
               sum_d     = '0;
               co_d      = 1'b0;
               cin_msb_d = 1'b0;
            end
         end
         S_RUN: begin
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_co;
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               cin_msb_d = carry_q;
               co_d      = fa_co;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         co_q      <= 1'b0;
         cin_msb_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         co_q      <= co_d;
         cin_msb_q <= cin_msb_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign co        = co_q;
   assign ovf       = cin_msb_q ^ co_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It accepts two WIDTH-bit operands over a valid/ready handshake and sequences a single 1-bit full adder instance (fulladd) LSB-first across WIDTH clock cycles. The carry is held in a register between bits. The block then presents the WIDTH-bit sum, carry-out and signed overflow on an output handshake. It is the small-area arithmetic unit for HW-level datapaths that cannot afford a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, ci are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in for bit 0.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- co  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: busy=1.
  - DONE: out_valid=1.
- IDLE -> RUN on an edge with in_valid & in_ready (the accept edge). On that edge:
  - a_sr<=a, b_sr<=b, carry<=ci, cnt<=0.
  - sum is cleared to 0.
- RUN, each edge:
  - fulladd inputs are a_sr[0], b_sr[0] and carry.
  - sum shifts right, with s entering bit WIDTH-1.
  - carry<=co of the adder; a_sr and b_sr shift right; cnt<=cnt+1.
- RUN, edge where cnt==WIDTH-1:
  - cin_msb<=carry (carry before update), so ovf = cin_msb ^ co.
  - State -> DONE.
- DONE -> IDLE on an edge with out_ready.
  - sum, co and ovf hold their values until the next accept edge.
- In RUN and DONE:
  - in_valid is ignored; a, b, ci and sub are sampled only on the accept edge.
- Arithmetic is modulo 2^WIDTH: {co,sum} = a + b + ci.
- Reset (any state, including mid-RUN): outputs and state registers are forced immediately.
  - State=IDLE; sum=0, co=0, ovf=0, out_valid=0, busy=0, in_ready=1.
  - Any partial result is discarded and no out_valid is produced.

## Timing
- Accept edge T0. Bits 0..WIDTH-1 are processed on edges T1..TWIDTH.
- out_valid is high after edge TWIDTH (latency WIDTH cycles from accept to out_valid).
- The output handshake completes on the first edge with out_valid & out_ready. in_ready rises after that edge.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH bit cycles, DONE, IDLE.
- out_ready held low keeps DONE indefinitely; sum, co and ovf stay stable.
- out_ready high while not in DONE has no effect.
- All outputs are registered or decoded from state; there is no combinational input-to-output path.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at the accept edge: b_sr<=~b, carry<=1, and ci is ignored.
  - co=1 means no borrow. ovf is signed-subtraction overflow.
- SERIAL_ADD_SUB_EN undefined:
  - No sub port; add only.
  - Logic is otherwise identical.

## Test plan
All cases use WIDTH=8.
- 8'h0F + 8'h01, ci=0 -> sum 8'h10, co=0, ovf=0; out_valid rises exactly 8 edges after the accept edge.
- 8'hFF + 8'h01, ci=0 -> sum 8'h00, co=1, ovf=0. Also 8'h7F + 8'h00, ci=1 -> sum 8'h80, co=0, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with new operands meanwhile -> result unchanged, in_ready=0, new operands not accepted. Release out_ready -> IDLE, then the next operands are accepted.
- Assert reset after the edge processing bit 3 of 8'hAA + 8'h55 -> out_valid=0, sum=0, co=0, busy=0 immediately. Deassert reset, then issue 8'h01 + 8'h01 -> sum 8'h02.
- Back-to-back: in_valid and out_ready held high, three operations -> accept edges spaced exactly 10 cycles apart, all results correct.
- SERIAL_ADD_SUB_EN: sub=1, 8'h05 - 8'h07 -> sum 8'hFE, co=0, ovf=0. sub=1, 8'h80 - 8'h01 -> sum 8'h7F, co=1, ovf=1.
